// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler, fetcher and decoder.
package gpu_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t CORE_IDLE    = 3'b000;
  localparam phase_t CORE_FETCH   = 3'b001;
  localparam phase_t CORE_DECODE  = 3'b010;
  localparam phase_t CORE_REQUEST = 3'b011;
  localparam phase_t CORE_WAIT    = 3'b100;
  localparam phase_t CORE_EXECUTE = 3'b101;
  localparam phase_t CORE_UPDATE  = 3'b110;
  localparam phase_t CORE_DONE    = 3'b111;

  localparam phase_t FETCH_IDLE     = 3'b000;
  localparam phase_t FETCH_FETCHING = 3'b001;
  localparam phase_t FETCH_FETCHED  = 3'b010;

endpackage

// File: rtl/fetcher_if.sv
// Program-memory read channel between the fetcher (master) and the memory controller (slave).
interface fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  // Valid/ready: the master raises mem_read_valid with a stable mem_read_address and holds both
  // until the slave returns mem_read_ready with mem_read_data in the same cycle; the transfer
  // completes on that edge and valid drops in the following cycle. Ready without valid means nothing.
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill, valid bits cleared on reset.
module fetch_icache #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_address,
  input  logic                 fill,
  input  logic [ADDR_BITS-1:0] fill_address,
  input  logic [DATA_BITS-1:0] fill_data,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     line_valid;
  logic [TAG_BITS-1:0]  line_tag  [LINES];
  logic [DATA_BITS-1:0] line_data [LINES];

  logic [INDEX_BITS-1:0] lookup_index, fill_index;
  logic [TAG_BITS-1:0]   lookup_tag, fill_tag;

  assign lookup_index = lookup_address[INDEX_BITS-1:0];
  assign lookup_tag   = lookup_address[ADDR_BITS-1:INDEX_BITS];
  assign fill_index   = fill_address[INDEX_BITS-1:0];
  assign fill_tag     = fill_address[ADDR_BITS-1:INDEX_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are never consulted while the line's valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= fill_data;
    end
  end

  assign hit      = line_valid[lookup_index] && (line_tag[lookup_index] == lookup_tag);
  assign hit_data = line_data[lookup_index];
endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: fetches one word per FETCH over a valid/ready read channel and holds it
// for DECODE. Define FETCHER_CACHE_EN to compile in the direct-mapped cache (fetch_icache).
module fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  fetcher_if.master                        mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

  if ((CACHE_LINES < 2) || ((CACHE_LINES & (CACHE_LINES - 1)) != 0)) begin : g_bad_cache_lines
    $error("fetcher: CACHE_LINES must be a power of two and at least 2");
  end

`ifdef FETCHER_CACHE_EN
  fetch_icache #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache (
    .clk            (clk),
    .reset          (reset),
    .lookup_address (current_pc),
    .fill           ((fetcher_state == FETCH_FETCHING) && mem.mem_read_ready),
    .fill_address   (mem.mem_read_address),
    .fill_data      (mem.mem_read_data),
    .hit            (cache_hit),
    .hit_data       (cache_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetcher_state        <= FETCH_IDLE;
      mem.mem_read_valid   <= 1'b0;
      mem.mem_read_address <= '0;
      instruction          <= '0;
    end else begin
      case (fetcher_state)
        FETCH_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (cache_hit) begin
              instruction   <= cache_data;
              fetcher_state <= FETCH_FETCHED;
            end else begin
              mem.mem_read_valid   <= 1'b1;
              mem.mem_read_address <= current_pc;
              fetcher_state        <= FETCH_FETCHING;
            end
          end
        end
        FETCH_FETCHING: begin
          // Valid and address stay put until the controller answers; one request per miss.
          if (mem.mem_read_ready) begin
            instruction        <= mem.mem_read_data;
            mem.mem_read_valid <= 1'b0;
            fetcher_state      <= FETCH_FETCHED;
          end
        end
        FETCH_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            fetcher_state <= FETCH_IDLE;
          end
        end
        default: begin
          fetcher_state      <= FETCH_IDLE;
          mem.mem_read_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher; follows FETCHER_CACHE_EN to decide whether repeat fetches may hit.
module tb_fetcher;
  import gpu_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LINES = 4;
`ifdef FETCHER_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    core_state = CORE_IDLE;
  logic [AW-1:0] current_pc = '0;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;

  fetcher_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mem_if ();

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS (AW),
    .PROGRAM_MEM_DATA_BITS (DW),
    .CACHE_LINES           (LINES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .mem           (mem_if),
    .fetcher_state (fetcher_state),
    .instruction   (instruction)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: program memory contents, cache contents (index -> cached pc), held word
  logic [DW-1:0] mem_model [256];
  int            line_pc [int];
  logic [DW-1:0] exp_instr;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input int pc);
    int idx = pc % LINES;
    return CACHE_ON && line_pc.exists(idx) && (line_pc[idx] == pc);
  endfunction

  // driver: one full fetch from FETCH request to FETCHED, with latency lat on a miss
  task automatic do_fetch(input int pc, input int lat);
    bit hit = model_hit(pc);
    mem_if.mem_read_ready = 1'b0;
    current_pc = pc[AW-1:0];
    core_state = CORE_FETCH;
    step();
    if (hit) begin
      n_cmp++;
      if (fetcher_state !== FETCH_FETCHED || instruction !== mem_model[pc] || mem_if.mem_read_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hit pc=%02h: state=%0d instr=%04h valid=%b, required state=2 instr=%04h valid=0",
                 pc, fetcher_state, instruction, mem_if.mem_read_valid, mem_model[pc]);
      end
    end else begin
      for (int i = 0; i < lat; i++) begin
        n_cmp++;
        if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== pc[AW-1:0] || fetcher_state !== FETCH_FETCHING) begin
          n_fail++;
          $display("FAIL request pc=%02h cyc=%0d: valid=%b addr=%02h state=%0d, required valid=1 addr=%02h state=1",
                   pc, i, mem_if.mem_read_valid, mem_if.mem_read_address, fetcher_state, pc);
        end
        if (i == lat - 1) begin
          mem_if.mem_read_ready = 1'b1;
          mem_if.mem_read_data  = mem_model[pc];
        end else begin
          mem_if.mem_read_data  = DW'($urandom);
        end
        step();
      end
      mem_if.mem_read_ready = 1'b0;
      mem_if.mem_read_data  = DW'($urandom);
      n_cmp++;
      if (fetcher_state !== FETCH_FETCHED || instruction !== mem_model[pc] || mem_if.mem_read_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fill pc=%02h: state=%0d instr=%04h valid=%b, required state=2 instr=%04h valid=0",
                 pc, fetcher_state, instruction, mem_if.mem_read_valid, mem_model[pc]);
      end
      line_pc[pc % LINES] = pc;
    end
    exp_instr = mem_model[pc];
  endtask

  task automatic hold_fetched(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      core_state = (i % 2 == 0) ? CORE_EXECUTE : CORE_FETCH;
      step();
      n_cmp++;
      if (fetcher_state !== FETCH_FETCHED || instruction !== exp_instr) begin
        n_fail++;
        $display("FAIL hold cyc=%0d: state=%0d instr=%04h, required state=2 instr=%04h",
                 i, fetcher_state, instruction, exp_instr);
      end
    end
  endtask

  task automatic release_decode();
    core_state = CORE_DECODE;
    step();
    core_state = CORE_EXECUTE;
    n_cmp++;
    if (fetcher_state !== FETCH_IDLE || instruction !== exp_instr) begin
      n_fail++;
      $display("FAIL release: state=%0d instr=%04h, required state=0 instr=%04h",
               fetcher_state, instruction, exp_instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data = '0;
    step();
    step();
    reset = 1'b0;
    line_pc.delete();
    exp_instr = '0;
    n_cmp++;
    if (fetcher_state !== FETCH_IDLE || mem_if.mem_read_valid !== 1'b0 ||
        mem_if.mem_read_address !== '0 || instruction !== '0) begin
      n_fail++;
      $display("FAIL reset: state=%0d valid=%b addr=%02h instr=%04h, required all 0",
               fetcher_state, mem_if.mem_read_valid, mem_if.mem_read_address, instruction);
    end
  endtask

  task automatic test_first_fetch_and_hold();
    do_fetch(8'h05, 3);
    hold_fetched(5);
    release_decode();
  endtask

  task automatic test_cache_hit();
    do_fetch(8'h05, 2);
    release_decode();
  endtask

  task automatic test_conflict();
    do_fetch(8'h01, 1);
    release_decode();
    do_fetch(8'h05, 2);
    release_decode();
    do_fetch(8'h01, 2);
    release_decode();
  endtask

  task automatic test_reset_mid();
    current_pc = 8'h20;
    core_state = CORE_FETCH;
    step();
    core_state = CORE_WAIT;
    step();
    n_cmp++;
    if (mem_if.mem_read_valid !== 1'b1 || fetcher_state !== FETCH_FETCHING) begin
      n_fail++;
      $display("FAIL mid_request: valid=%b state=%0d, required valid=1 state=1",
               mem_if.mem_read_valid, fetcher_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    line_pc.delete();
    exp_instr = '0;
    n_cmp++;
    if (mem_if.mem_read_valid !== 1'b0 || fetcher_state !== FETCH_IDLE || instruction !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b state=%0d instr=%04h, required 0/0/0",
               mem_if.mem_read_valid, fetcher_state, instruction);
    end
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'hbeef;
    step();
    mem_if.mem_read_ready = 1'b0;
    n_cmp++;
    if (mem_if.mem_read_valid !== 1'b0 || fetcher_state !== FETCH_IDLE || instruction !== '0) begin
      n_fail++;
      $display("FAIL late_ready: valid=%b state=%0d instr=%04h, required 0/0/0",
               mem_if.mem_read_valid, fetcher_state, instruction);
    end
    do_fetch(8'h20, 2);
    release_decode();
  endtask

  task automatic test_spurious();
    core_state = CORE_EXECUTE;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'hdead;
    step();
    mem_if.mem_read_ready = 1'b0;
    n_cmp++;
    if (fetcher_state !== FETCH_IDLE || mem_if.mem_read_valid !== 1'b0 || instruction !== exp_instr) begin
      n_fail++;
      $display("FAIL ready_in_idle: state=%0d valid=%b instr=%04h, required state=0 valid=0 instr=%04h",
               fetcher_state, mem_if.mem_read_valid, instruction, exp_instr);
    end
    do_fetch(8'h3a, 1);
    current_pc = 8'h77;
    core_state = CORE_FETCH;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = ~exp_instr;
    step();
    mem_if.mem_read_ready = 1'b0;
    n_cmp++;
    if (fetcher_state !== FETCH_FETCHED || mem_if.mem_read_valid !== 1'b0 || instruction !== exp_instr) begin
      n_fail++;
      $display("FAIL spurious_in_fetched: state=%0d valid=%b instr=%04h, required state=2 valid=0 instr=%04h",
               fetcher_state, mem_if.mem_read_valid, instruction, exp_instr);
    end
    release_decode();
  endtask

  task automatic test_back_to_back();
    int pool [4] = '{8'h05, 8'h01, 8'h09, 8'hff};
    int pc;
    for (int k = 0; k < 24; k++) begin
      pc = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : int'($urandom_range(0, 255));
      do_fetch(pc, int'($urandom_range(1, 4)));
      hold_fetched(int'($urandom_range(0, 3)));
      release_decode();
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem_model[a] = DW'($urandom);
    mem_model[8'h05] = 16'h9105;
    test_reset();
    test_first_fetch_and_hold();
    test_cache_hit();
    test_conflict();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
